// File: rtl/half_adder_reg_if.sv
// half_adder_reg_if -- operand/result bundle for the registered half adder.
//
// Signals:
//   in_valid  : a/b carry a valid operand set this cycle
//   a, b      : WIDTH-bit operands, one bit per lane
//   out_valid : sum/carry hold a freshly registered result
//   sum       : per-lane a XOR b
//   carry     : per-lane a AND b
//   any_carry : OR of registered carry lanes, qualified by out_valid
//   carry_cnt : saturating carry-event count (only with HALF_ADDER_REG_STATS_EN)
//
// Modports: master drives operands and observes results; slave is the adder.
interface half_adder_reg_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             any_carry;
`ifdef HALF_ADDER_REG_STATS_EN
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry, any_carry, carry_cnt
  );
  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry, any_carry, carry_cnt
  );
`else
  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry, any_carry
  );
  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry, any_carry
  );
`endif
endinterface

// File: rtl/half_adder_reg.sv
// half_adder_reg -- registered, vectorised half adder.
//
// WIDTH independent lanes each produce sum = a ^ b and carry = a & b,
// registered with one cycle of latency and a valid qualifier. Full
// throughput, no backpressure.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : half_adder_reg_if.slave (in_valid/a/b in, out_valid/sum/carry/
//           any_carry[/carry_cnt] out)
//
// Optional feature macro: HALF_ADDER_REG_STATS_EN
//   When defined, bus.carry_cnt counts registered results with at least one
//   carry lane, saturating at all-ones. When undefined, the counter is absent.
module half_adder_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  half_adder_reg_if.slave   bus
);

  // Elaboration-time legality of the configuration.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "half_adder_reg: WIDTH out of range 1..64");
  end
  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    $fatal(1, "half_adder_reg: CNT_W out of range 4..32");
  end

  // True when any lane of the operand pair would generate a carry.
  function automatic logic carry_any(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
    carry_any = |(x & y);
  endfunction

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] carry_r;
  logic             any_carry_r;

  // Result registers: reset wins over in_valid; idle cycles keep sum/carry
  // stable and never look at a/b, so garbage operands cannot leak out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= {WIDTH{1'b0}};
      any_carry_r <= 1'b0;
    end else if (bus.in_valid) begin
      out_valid_r <= 1'b1;
      sum_r       <= bus.a ^ bus.b;
      carry_r     <= bus.a & bus.b;
      any_carry_r <= carry_any(bus.a, bus.b);
    end else begin
      out_valid_r <= 1'b0;
      sum_r       <= sum_r;
      carry_r     <= carry_r;
      any_carry_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.any_carry = any_carry_r;

`ifdef HALF_ADDER_REG_STATS_EN
  logic [CNT_W-1:0] carry_cnt_r;

  // Carry-event counter: counts the same events that set any_carry, and
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.in_valid && carry_any(bus.a, bus.b) &&
                 (carry_cnt_r != {CNT_W{1'b1}})) begin
      carry_cnt_r <= carry_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      carry_cnt_r <= carry_cnt_r;
    end
  end

  assign bus.carry_cnt = carry_cnt_r;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
// tb_half_adder_reg -- directed, table-driven bench for half_adder_reg
// (WIDTH = 8, CNT_W = 4). Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
module tb_half_adder_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk;
  logic rst_n;

  half_adder_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  half_adder_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      nm;
    logic       rst_n;
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       ev;
    logic [7:0] es;
    logic [7:0] ec;
    logic       ea;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one operand set before a rising edge, return just after it.
  task automatic step(input logic r, input logic v, input logic [7:0] aa, input logic [7:0] bb);
    @(negedge clk);
    rst_n       = r;
    bus.in_valid = v;
    bus.a       = aa;
    bus.b       = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [7:0] es,
                         input logic [7:0] ec, input logic ea);
    chk({nm, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, ev});
    chk({nm, ".sum"},       {56'd0, bus.sum},       {56'd0, es});
    chk({nm, ".carry"},     {56'd0, bus.carry},     {56'd0, ec});
    chk({nm, ".any_carry"}, {63'd0, bus.any_carry}, {63'd0, ea});
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;

    // name, rst_n, in_valid, a, b -> out_valid, sum, carry, any_carry
    tbl[0] = '{"tt00",  1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{"tt01",  1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 8'h01, 8'h00, 1'b0};
    tbl[2] = '{"tt10",  1'b1, 1'b1, 8'h01, 8'h00, 1'b1, 8'h01, 8'h00, 1'b0};
    tbl[3] = '{"tt11",  1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 8'h00, 8'h01, 1'b1};
    tbl[4] = '{"lanes1",1'b1, 1'b1, 8'hF0, 8'hCC, 1'b1, 8'h3C, 8'hC0, 1'b1};
    tbl[5] = '{"lanes2",1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 8'hFF, 8'h00, 1'b0};
    tbl[6] = '{"alt",   1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 8'hFF, 8'h00, 1'b0};
    tbl[7] = '{"ones",  1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1};
    tbl[8] = '{"msb",   1'b1, 1'b1, 8'h80, 8'h81, 1'b1, 8'h01, 8'h80, 1'b1};
    tbl[9] = '{"holdsrc",1'b1,1'b1, 8'h01, 8'h00, 1'b1, 8'h01, 8'h00, 1'b0};

    // Reset held for two edges with valid 1+1 operands present.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 8'h01, 8'h01);
      chk_out($sformatf("reset%0d", i), 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef HALF_ADDER_REG_STATS_EN
      chk($sformatf("reset%0d.carry_cnt", i), {60'd0, bus.carry_cnt}, 64'd0);
`endif
    end

    // Back-to-back vectors: each result must appear right after its edge.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst_n, tbl[i].v, tbl[i].a, tbl[i].b);
      chk_out(tbl[i].nm, tbl[i].ev, tbl[i].es, tbl[i].ec, tbl[i].ea);
    end

    // Idle hold: operands are junk (2-state stand-in for X) while in_valid=0.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
      chk_out($sformatf("idle%0d", i), 1'b0, 8'h01, 8'h00, 1'b0);
    end

    // Mid-stream reset discards the in-flight result, then streaming resumes.
    step(1'b1, 1'b1, 8'h01, 8'h01);
    chk_out("mid.pre", 1'b1, 8'h00, 8'h01, 1'b1);
    step(1'b0, 1'b1, 8'h01, 8'h01);
    chk_out("mid.rst", 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h01, 8'h01);
    chk_out("mid.resume", 1'b1, 8'h00, 8'h01, 1'b1);

`ifdef HALF_ADDER_REG_STATS_EN
    // Saturating carry counter: 20 carry events on a 4-bit counter.
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("stats.clear", {60'd0, bus.carry_cnt}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'h01, 8'h01);
      chk($sformatf("stats.cnt%0d", i), {60'd0, bus.carry_cnt},
          64'((i + 1 > 15) ? 15 : i + 1));
    end
    step(1'b1, 1'b1, 8'h01, 8'h00);
    chk("stats.nocarry", {60'd0, bus.carry_cnt}, 64'd15);
    step(1'b1, 1'b0, 8'hFF, 8'hFF);
    chk("stats.idle", {60'd0, bus.carry_cnt}, 64'd15);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    chk("stats.reset", {60'd0, bus.carry_cnt}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
